// File: rtl/hazard_stall_ctrl.sv
// RAW hazard detector and ID/EX stall controller with memory freeze,
// a small run/hazard/mem-wait FSM, saturating statistics and a stall watchdog.
module hazard_stall_ctrl #(
   parameter int REG_ADDR_W = 4,
   parameter int NUM_SRC    = 3,
   parameter int CNT_W      = 16,
   parameter int MAX_STALL  = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          id_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic [REG_ADDR_W-1:0]         exe_dest,
   input  logic                          exe_wb_en,
   input  logic                          exe_mem_read,
   input  logic [REG_ADDR_W-1:0]         mem_dest,
   input  logic                          mem_wb_en,
   input  logic                          mem_busy,
   input  logic                          forwarding_mode,
   input  logic                          clr_stats,
   output logic                          hazard_detected,
   output logic                          stall_fe,
   output logic                          bubble_ex,
   output logic                          freeze,
   output logic [1:0]                    state,
   output logic [CNT_W-1:0]              stall_cycles,
   output logic [CNT_W-1:0]              hazard_events,
   output logic                          stall_timeout
);

   localparam logic [1:0] ST_RUN      = 2'b00;
   localparam logic [1:0] ST_HAZARD   = 2'b01;
   localparam logic [1:0] ST_MEM_WAIT = 2'b10;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_STALL);
   localparam logic [CNT_W-1:0] RUN_M1  = CNT_W'(MAX_STALL - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [NUM_SRC-1:0] ex_hit;
   logic [NUM_SRC-1:0] mem_hit;
   logic               raw;
   logic [1:0]         state_nxt;
   logic [CNT_W-1:0]   run_len;
   logic               stall_sat;
   logic               event_sat;
   logic               new_episode;
   logic               timeout_hit;

   always_comb begin
      ex_hit  = '0;
      mem_hit = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ex_hit[i]  = src_valid[i] & exe_wb_en &
                      (src_addr[i*REG_ADDR_W +: REG_ADDR_W] == exe_dest);
         mem_hit[i] = src_valid[i] & mem_wb_en &
                      (src_addr[i*REG_ADDR_W +: REG_ADDR_W] == mem_dest);
      end
   end

   // with forwarding, only a load in EXE cannot be bypassed in time
   always_comb begin
      if (forwarding_mode) begin
         raw = exe_mem_read & (|ex_hit);
      end else begin
         raw = (|ex_hit) | (|mem_hit);
      end
   end

   assign hazard_detected = id_valid & raw;
   assign freeze          = mem_busy;
   assign stall_fe        = hazard_detected | freeze;
   assign bubble_ex       = hazard_detected & ~freeze;

   always_comb begin
      state_nxt = ST_RUN;
      unique case (1'b1)
         mem_busy:                     state_nxt = ST_MEM_WAIT;
         (~mem_busy & hazard_detected): state_nxt = ST_HAZARD;
         default:                      state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   assign stall_sat   = (stall_cycles == CNT_MAX);
   assign event_sat   = (hazard_events == CNT_MAX);
   assign new_episode = bubble_ex & (state != ST_HAZARD);
   assign timeout_hit = stall_fe & (run_len == RUN_M1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
      end else if (clr_stats) begin
         stall_cycles <= '0;
      end else if (stall_fe && !stall_sat) begin
         stall_cycles <= stall_cycles + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hazard_events <= '0;
      end else if (clr_stats) begin
         hazard_events <= '0;
      end else if (new_episode && !event_sat) begin
         hazard_events <= hazard_events + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_len <= '0;
      end else if (clr_stats || !stall_fe) begin
         run_len <= '0;
      end else if (run_len != RUN_MAX) begin
         run_len <= run_len + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_timeout <= 1'b0;
      end else if (clr_stats) begin
         stall_timeout <= 1'b0;
      end else if (timeout_hit) begin
         stall_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized
// traffic checked against a cycle-level reference model.
module tb_hazard_stall_ctrl;

   localparam int RW   = 4;
   localparam int NS   = 3;
   localparam int CW   = 4;
   localparam int MS   = 4;
   localparam int CMAX = 15;

   logic            clk;
   logic            rst;
   logic            id_valid;
   logic [NS*RW-1:0] src_addr;
   logic [NS-1:0]   src_valid;
   logic [RW-1:0]   exe_dest;
   logic            exe_wb_en;
   logic            exe_mem_read;
   logic [RW-1:0]   mem_dest;
   logic            mem_wb_en;
   logic            mem_busy;
   logic            forwarding_mode;
   logic            clr_stats;
   logic            hazard_detected;
   logic            stall_fe;
   logic            bubble_ex;
   logic            freeze;
   logic [1:0]      state;
   logic [CW-1:0]   stall_cycles;
   logic [CW-1:0]   hazard_events;
   logic            stall_timeout;

   int errors = 0;
   int checks = 0;

   int m_state  = 0;
   int m_stall  = 0;
   int m_events = 0;
   int m_consec = 0;
   bit m_to     = 0;

   hazard_stall_ctrl #(
      .REG_ADDR_W(RW), .NUM_SRC(NS), .CNT_W(CW), .MAX_STALL(MS)
   ) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .src_addr(src_addr), .src_valid(src_valid),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
      .exe_mem_read(exe_mem_read), .mem_dest(mem_dest),
      .mem_wb_en(mem_wb_en), .mem_busy(mem_busy),
      .forwarding_mode(forwarding_mode), .clr_stats(clr_stats),
      .hazard_detected(hazard_detected), .stall_fe(stall_fe),
      .bubble_ex(bubble_ex), .freeze(freeze), .state(state),
      .stall_cycles(stall_cycles), .hazard_events(hazard_events),
      .stall_timeout(stall_timeout)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit");
      $fatal(1, "timeout");
   end

   task automatic clear_inputs();
      id_valid = 0; src_addr = '0; src_valid = '0;
      exe_dest = '0; exe_wb_en = 0; exe_mem_read = 0;
      mem_dest = '0; mem_wb_en = 0; mem_busy = 0;
      forwarding_mode = 0; clr_stats = 0;
   endtask

   task automatic set_src(input int i, input int a, input bit v);
      logic [RW-1:0] av;
      av = a[RW-1:0];
      src_addr[i*RW +: RW] = av;
      src_valid[i] = v;
   endtask

   // does any read operand name a register still pending in EXE/MEM?
   function automatic bit m_haz();
      bit any_ex = 0;
      bit any_mem = 0;
      for (int i = 0; i < NS; i++) begin
         int a;
         a = int'(src_addr[i*RW +: RW]);
         if (src_valid[i] && exe_wb_en && a == int'(exe_dest)) any_ex = 1;
         if (src_valid[i] && mem_wb_en && a == int'(mem_dest)) any_mem = 1;
      end
      if (!id_valid) return 0;
      if (forwarding_mode) return exe_mem_read && any_ex;
      return any_ex || any_mem;
   endfunction

   task automatic m_reset();
      m_state = 0; m_stall = 0; m_events = 0; m_consec = 0; m_to = 0;
   endtask

   task automatic tick();
      bit h, sf, bb, clr, busy;
      h = m_haz(); busy = mem_busy; clr = clr_stats;
      sf = h || busy; bb = h && !busy;
      @(posedge clk);
      if (!rst) begin
         m_reset();
      end else begin
         if (clr) begin
            m_stall = 0; m_events = 0; m_consec = 0; m_to = 0;
         end else begin
            if (sf && m_stall < CMAX) m_stall++;
            if (bb && m_state != 1 && m_events < CMAX) m_events++;
            if (sf) begin
               if (m_consec + 1 >= MS) m_to = 1;
               m_consec++;
            end else begin
               m_consec = 0;
            end
         end
         m_state = busy ? 2 : (h ? 1 : 0);
      end
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 0;
      #12;
      checks++;
      if (state !== 2'b00) begin
         errors++; $display("FAIL reset_state got=%0d exp=0", state);
      end
      checks++;
      if (stall_cycles !== '0 || hazard_events !== '0) begin
         errors++;
         $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, hazard_events);
      end
      checks++;
      if (stall_timeout !== 1'b0) begin
         errors++; $display("FAIL reset_timeout got=%0b exp=0", stall_timeout);
      end
      rst = 1;
      m_reset();
      tick();
   endtask

   task automatic test_fwd_off_ex();
      clear_inputs();
      id_valid = 1; set_src(0, 3, 1); exe_dest = 3; exe_wb_en = 1;
      #1;
      checks++;
      if (hazard_detected !== 1'b1 || bubble_ex !== 1'b1 || stall_fe !== 1'b1) begin
         errors++;
         $display("FAIL ex_hit got=%0b%0b%0b exp=111", hazard_detected, bubble_ex, stall_fe);
      end
      tick();
      checks++;
      if (state !== 2'b01) begin
         errors++; $display("FAIL ex_hit_state got=%0d exp=1", state);
      end
      checks++;
      if (hazard_events !== CW'(m_events)) begin
         errors++; $display("FAIL ex_hit_events got=%0d exp=%0d", hazard_events, m_events);
      end
      tick();
      checks++;
      if (hazard_events !== CW'(m_events)) begin
         errors++; $display("FAIL episode_once got=%0d exp=%0d", hazard_events, m_events);
      end
   endtask

   task automatic test_fwd_on_load_use();
      int ev0;
      clear_inputs();
      tick();
      ev0 = m_events;
      forwarding_mode = 1; id_valid = 1; set_src(0, 3, 1);
      exe_dest = 3; exe_wb_en = 1; exe_mem_read = 0;
      mem_dest = 3; mem_wb_en = 1;
      #1;
      checks++;
      if (hazard_detected !== 1'b0) begin
         errors++; $display("FAIL fwd_no_load got=%0b exp=0", hazard_detected);
      end
      exe_mem_read = 1;
      #1;
      checks++;
      if (hazard_detected !== 1'b1) begin
         errors++; $display("FAIL fwd_load_use got=%0b exp=1", hazard_detected);
      end
      tick();
      checks++;
      if (hazard_events !== CW'(ev0 + 1)) begin
         errors++; $display("FAIL fwd_events got=%0d exp=%0d", hazard_events, ev0 + 1);
      end
   endtask

   task automatic test_mem_src2();
      clear_inputs();
      id_valid = 1; set_src(2, 7, 1); mem_dest = 7; mem_wb_en = 1;
      #1;
      checks++;
      if (hazard_detected !== 1'b1) begin
         errors++; $display("FAIL mem_src2 got=%0b exp=1", hazard_detected);
      end
      src_valid[2] = 0;
      #1;
      checks++;
      if (hazard_detected !== 1'b0) begin
         errors++; $display("FAIL mem_src2_invalid got=%0b exp=0", hazard_detected);
      end
      src_valid[2] = 1; id_valid = 0;
      #1;
      checks++;
      if (hazard_detected !== 1'b0 || stall_fe !== 1'b0) begin
         errors++; $display("FAIL id_invalid got=%0b%0b exp=00", hazard_detected, stall_fe);
      end
      tick();
   endtask

   task automatic test_freeze();
      clear_inputs();
      id_valid = 1; set_src(1, 5, 1); exe_dest = 5; exe_wb_en = 1;
      mem_busy = 1;
      #1;
      checks++;
      if (freeze !== 1'b1 || stall_fe !== 1'b1 || bubble_ex !== 1'b0) begin
         errors++;
         $display("FAIL freeze got=%0b%0b%0b exp=110", freeze, stall_fe, bubble_ex);
      end
      tick();
      checks++;
      if (state !== 2'b10) begin
         errors++; $display("FAIL freeze_state got=%0d exp=2", state);
      end
   endtask

   task automatic test_timeout();
      clear_inputs();
      tick();
      clr_stats = 1;
      tick();
      clr_stats = 0;
      mem_busy = 1;
      for (int k = 1; k <= MS; k++) begin
         tick();
         checks++;
         if (stall_timeout !== (k == MS)) begin
            errors++; $display("FAIL timeout_edge%0d got=%0b exp=%0b", k, stall_timeout, k == MS);
         end
      end
      mem_busy = 0;
      tick();
      tick();
      checks++;
      if (stall_timeout !== 1'b1) begin
         errors++; $display("FAIL timeout_sticky got=%0b exp=1", stall_timeout);
      end
      mem_busy = 1; clr_stats = 1;
      tick();
      clr_stats = 0;
      checks++;
      if (stall_timeout !== 1'b0 || stall_cycles !== '0) begin
         errors++;
         $display("FAIL clr_priority got=%0b/%0d exp=0/0", stall_timeout, stall_cycles);
      end
      mem_busy = 0;
      tick();
   endtask

   task automatic test_saturation();
      clear_inputs();
      mem_busy = 1;
      for (int k = 0; k < 20; k++) tick();
      checks++;
      if (stall_cycles !== CW'(CMAX)) begin
         errors++; $display("FAIL stall_sat got=%0d exp=%0d", stall_cycles, CMAX);
      end
      checks++;
      if (hazard_events !== CW'(m_events)) begin
         errors++; $display("FAIL freeze_no_event got=%0d exp=%0d", hazard_events, m_events);
      end
      mem_busy = 0;
      tick();
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      id_valid = 1; set_src(0, 9, 1); exe_dest = 9; exe_wb_en = 1;
      tick();
      tick();
      checks++;
      if (state !== 2'b01 || stall_cycles === '0) begin
         errors++; $display("FAIL pre_reset got=%0d/%0d exp=1/>0", state, stall_cycles);
      end
      #2;
      rst = 0;
      #1;
      checks++;
      if (state !== 2'b00 || stall_cycles !== '0 || hazard_events !== '0
          || stall_timeout !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got=%0d/%0d/%0d/%0b exp=0/0/0/0",
                  state, stall_cycles, hazard_events, stall_timeout);
      end
      checks++;
      if (hazard_detected !== 1'b1 || bubble_ex !== 1'b1) begin
         errors++;
         $display("FAIL comb_in_reset got=%0b%0b exp=11", hazard_detected, bubble_ex);
      end
      m_reset();
      rst = 1;
      clear_inputs();
      tick();
   endtask

   task automatic test_random();
      bit h;
      for (int n = 0; n < 400; n++) begin
         id_valid        = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < NS; i++)
            set_src(i, $urandom_range(0, 3), $urandom_range(0, 1));
         exe_dest        = RW'($urandom_range(0, 3));
         mem_dest        = RW'($urandom_range(0, 3));
         exe_wb_en       = $urandom_range(0, 1);
         mem_wb_en       = $urandom_range(0, 1);
         exe_mem_read    = $urandom_range(0, 1);
         forwarding_mode = $urandom_range(0, 1);
         mem_busy        = ($urandom_range(0, 3) == 0);
         clr_stats       = ($urandom_range(0, 19) == 0);
         #1;
         h = m_haz();
         checks++;
         if (hazard_detected !== h || freeze !== mem_busy ||
             stall_fe !== (h | mem_busy) || bubble_ex !== (h & ~mem_busy)) begin
            errors++;
            $display("FAIL rnd_comb n=%0d got=%0b%0b%0b%0b exp=%0b%0b%0b%0b", n,
                     hazard_detected, freeze, stall_fe, bubble_ex,
                     h, mem_busy, h | mem_busy, h & ~mem_busy);
         end
         tick();
         checks++;
         if (state !== 2'(m_state) || stall_cycles !== CW'(m_stall) ||
             hazard_events !== CW'(m_events) || stall_timeout !== m_to) begin
            errors++;
            $display("FAIL rnd_reg n=%0d got=%0d/%0d/%0d/%0b exp=%0d/%0d/%0d/%0b", n,
                     state, stall_cycles, hazard_events, stall_timeout,
                     m_state, m_stall, m_events, m_to);
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_fwd_off_ex();
      test_fwd_on_load_use();
      test_mem_src2();
      test_freeze();
      test_timeout();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
